// File: rtl/ram_cmd_queue.sv
// ram_cmd_queue
//
// Command front-end for the RAM subsystem. Read/write requests from a
// valid/ready master are buffered in a small circular FIFO and issued one at a
// time to the subsystem. Read data comes back on a valid/ready response
// channel. Writes produce no response.
//
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   cmd_valid/ready command handshake (cmd_ready = FIFO not full)
//   cmd_rw          1 = write, 0 = read
//   cmd_addr        command address
//   cmd_wdata       write data (ignored for reads)
//   rsp_valid/ready response handshake, rsp_rdata held while rsp_valid
//   mem_start       one-cycle request pulse to the subsystem
//   mem_rw, mem_address, mem_write_data   issued command, held while in flight
//   mem_read_data   subsystem read data, valid with mem_done
//   mem_done        subsystem completion
//   count           FIFO occupancy 0..FIFO_DEPTH
//   busy            a command is being issued, waited on or answered
module ram_cmd_queue #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_start,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_done,
    output logic [CW-1:0]         count,
    output logic                  busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, next_state;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          full;
    logic          push;
    logic          pop;

    // Ready depends on the registered count only, so a full FIFO stays
    // not-ready even in a cycle where the head is being popped.
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && (count_q != '0);
    assign count     = count_q;

    // Storage needs no reset: only entries counted by count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // mem_done only matters in WAIT; in ISSUE, IDLE and RESP it is ignored.
    always_comb begin
        next_state = state;
        mem_start  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (count_q != '0) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_start  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    next_state = mem_rw ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Issue registers are loaded on pop and then held until the next pop,
    // which keeps them stable for the whole in-flight period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rw         <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else if (pop) begin
            {mem_rw, mem_address, mem_write_data} <= fifo_mem[rd_ptr];
        end
    end

    // Read data is captured only on completion of a read, then held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if ((state == S_WAIT) && mem_done && !mem_rw) begin
            rsp_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_ram_cmd_queue.sv
// tb_ram_cmd_queue
//
// Drives ram_cmd_queue against a behavioural RAM subsystem. Accepted commands
// are pushed into expected-issue and expected-response queues; the subsystem
// model and response monitor pop and compare them as the DUT produces output.
module tb_ram_cmd_queue;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_start;
    logic          mem_rw;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_done = 1'b0;
    logic [CW-1:0] count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    logic mem_hold    = 1'b0;
    logic inject_done = 1'b0;
    int   mem_latency = 2;

    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];

    logic [16:0]   exp_issue [$];
    logic [DW-1:0] exp_rsp   [$];

    logic          pending = 1'b0;
    int            lat = 0;
    logic [16:0]   cur = '0;
    logic [16:0]   e_cmd;
    logic [DW-1:0] e_data;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_rdata = '0;

    ram_cmd_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .mem_start(mem_start),
        .mem_rw(mem_rw),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .mem_done(mem_done),
        .count(count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Single monitor process: scoreboard push on acceptance, response checking,
    // and the RAM subsystem model, all sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_issue.delete();
            exp_rsp.delete();
            shadow     = ram;
            pending    = 1'b0;
            prev_hold  = 1'b0;
            mem_done   = 1'b0;
            mem_read_data = 8'($urandom);
        end else begin
            if (prev_hold) begin
                checkOutput("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                checkOutput("rsp_hold_data", 32'(rsp_rdata), 32'(prev_rdata));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e_data = exp_rsp.pop_front();
                    checkOutput("rsp_data", 32'(rsp_rdata), 32'(e_data));
                end
            end
            prev_hold  = rsp_valid && !rsp_ready;
            prev_rdata = rsp_rdata;

            if (count == CW'(DEPTH)) begin
                checkOutput("ready_when_full", 32'(cmd_ready), 32'd0);
            end

            if (cmd_valid && cmd_ready) begin
                exp_issue.push_back({cmd_rw, cmd_addr, cmd_wdata});
                if (cmd_rw) begin
                    shadow[cmd_addr] = cmd_wdata;
                end else begin
                    exp_rsp.push_back(shadow[cmd_addr]);
                end
            end

            if (pending) begin
                checkOutput("mem_stable",
                    32'({mem_rw, mem_address, (cur[16] ? mem_write_data : 8'h00)}),
                    32'({cur[16], cur[15:8], (cur[16] ? cur[7:0] : 8'h00)}));
            end

            mem_done      = 1'b0;
            mem_read_data = 8'($urandom);
            if (inject_done) begin
                mem_done = 1'b1;
            end
            if (mem_start) begin
                starts++;
                if (exp_issue.size() == 0) begin
                    checkOutput("start_unexpected", 32'd1, 32'd0);
                end else begin
                    e_cmd = exp_issue.pop_front();
                    checkOutput("issue_rw", 32'(mem_rw), 32'(e_cmd[16]));
                    checkOutput("issue_addr", 32'(mem_address), 32'(e_cmd[15:8]));
                    if (e_cmd[16]) begin
                        checkOutput("issue_wdata", 32'(mem_write_data), 32'(e_cmd[7:0]));
                    end
                    cur = e_cmd;
                end
                if (mem_rw) begin
                    ram[mem_address] = mem_write_data;
                end
                pending = 1'b1;
                lat     = mem_latency;
            end else if (pending && !mem_hold) begin
                if (lat == 0) begin
                    mem_done      = 1'b1;
                    mem_read_data = ram[cur[15:8]];
                    pending       = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Present one command and hold it until the FIFO takes it.
    task automatic applyStimulus(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || count != '0 || exp_rsp.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checkOutput("idle_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("rst_mem_start", 32'(mem_start), 32'd0);
        checkOutput("rst_mem_rw", 32'(mem_rw), 32'd0);
        checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
        checkOutput("rst_mem_write_data", 32'(mem_write_data), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int snap;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single write then read");
        snap = starts;
        applyStimulus(1'b1, 8'h10, 8'hA5);
        applyStimulus(1'b0, 8'h10, 8'h00);
        waitIdle();
        checkOutput("wr_rd_starts", 32'(starts - snap), 32'd2);
        checkOutput("wr_rd_ram", 32'(ram[8'h10]), 32'hA5);

        $display("[TB] fill and backpressure");
        mem_hold    = 1'b1;
        mem_latency = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'(i), 8'h00);
        end
        @(negedge clk);
        checkOutput("fill_count", 32'(count), 32'(DEPTH));
        checkOutput("fill_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("blocked_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_hold = 1'b0;
        applyStimulus(1'b0, 8'd5, 8'h00);
        waitIdle();

        $display("[TB] response stall");
        applyStimulus(1'b1, 8'h20, 8'h3C);
        waitIdle();
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'h20, 8'($urandom));
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_rsp_seen", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        snap = starts;
        applyStimulus(1'b0, 8'h21, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_data", 32'(rsp_rdata), 32'h3C);
        end
        @(posedge clk);
        #1;
        checkOutput("stall_no_start", 32'(starts - snap), 32'd0);
        rsp_ready = 1'b1;
        waitIdle();

        $display("[TB] simultaneous push and pop");
        mem_hold    = 1'b1;
        mem_latency = 1;
        applyStimulus(1'b1, 8'h50, 8'h77);
        applyStimulus(1'b0, 8'h50, 8'h00);
        applyStimulus(1'b0, 8'h51, 8'h00);
        n = 0;
        @(negedge clk);
        while (count != CW'(2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pp_setup_count", 32'(count), 32'd2);
        @(posedge clk);
        #1;
        mem_hold = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_done && n < 50);
        checkOutput("pp_done_seen", 32'(mem_done), 32'd1);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 8'h52;
        @(negedge clk);
        checkOutput("pp_idle", 32'(busy), 32'd0);
        checkOutput("pp_count_before", 32'(count), 32'd2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("pp_count_after", 32'(count), 32'd2);
        waitIdle();

        $display("[TB] mixed commands across pointer wrap");
        for (int i = 0; i < 8; i++) begin
            mem_latency = $urandom_range(0, 3);
            applyStimulus(1'($urandom), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom));
        end
        waitIdle();

        $display("[TB] reset in WAIT then late done");
        mem_hold = 1'b1;
        applyStimulus(1'b0, 8'h30, 8'h00);
        applyStimulus(1'b0, 8'h31, 8'h00);
        applyStimulus(1'b0, 8'h32, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkResetValues();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_hold = 1'b0;
        inject_done = 1'b1;
        @(posedge clk);
        #1;
        inject_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("late_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("late_busy", 32'(busy), 32'd0);
            checkOutput("late_count", 32'(count), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_latency = 2;
        applyStimulus(1'b0, 8'h30, 8'h00);
        waitIdle();

        checkOutput("drain_issue", 32'(exp_issue.size()), 32'd0);
        checkOutput("drain_rsp", 32'(exp_rsp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_cmd_queue.md
# ram_cmd_queue

Command front-end that sits directly upstream of the RAM subsystem (controller + memory). Buffers read/write requests from a valid/ready master in a small FIFO and issues them one at a time on the subsystem's start/rw/address/write_data port. Waits for the subsystem's done and returns read data on a valid/ready response channel. Write commands produce no response.

## Interface
Parameters:
- ADDR_WIDTH, 8, address width; matches the RAM subsystem
- DATA_WIDTH, 8, data width; matches the RAM subsystem
- FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2
- CW, $clog2(FIFO_DEPTH)+1, derived width of `count`

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  master presents a command
- cmd_ready  out  1  FIFO can accept; equals !full (registered count only)
- cmd_rw  in  1  1 = write, 0 = read; passed unchanged to mem_rw
- cmd_addr  in  ADDR_WIDTH  command address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  master accepts response
- rsp_rdata  out  DATA_WIDTH  read data; held stable while rsp_valid
- mem_start  out  1  one-cycle request pulse to RAM subsystem
- mem_rw  out  1  to subsystem rw
- mem_address  out  ADDR_WIDTH  to subsystem address
- mem_write_data  out  DATA_WIDTH  to subsystem write_data
- mem_read_data  in  DATA_WIDTH  from subsystem read_data; valid in the cycle mem_done is high
- mem_done  in  1  subsystem completion
- count  out  CW  FIFO occupancy, 0..FIFO_DEPTH
- busy  out  1  state != IDLE

## Operation
- FIFO: circular buffer, rd/wr pointers of $clog2(FIFO_DEPTH) bits wrapping naturally, count register.
  - Push when cmd_valid && cmd_ready.
  - Pop only in IDLE when count != 0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, cmd_ready = 0 even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if count != 0, pop the head into the issue registers (mem_rw/mem_address/mem_write_data) and go to ISSUE.
  - ISSUE: mem_start = 1 for exactly this cycle; go to WAIT. mem_done is ignored in this cycle.
  - WAIT: hold issue registers. On mem_done:
    - Read: capture mem_read_data into rsp_rdata and go to RESP.
    - Write: go to IDLE.
  - RESP: rsp_valid = 1. On rsp_ready go to IDLE; otherwise hold rsp_valid and rsp_rdata.
- Only one command is in flight. Commands issue strictly in acceptance order.
- mem_done in IDLE or RESP is ignored, with no state change.
- Reset (at any time, including mid-WAIT): FIFO emptied, state IDLE, in-flight command dropped without waiting for mem_done.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, mem_start=0, mem_rw=0, mem_address=0, mem_write_data=0, count=0, busy=0.

## Timing
- Command accepted at edge E0: count=1 after E0. IDLE pops at E1. mem_start is high between E1 and E2 with mem_* outputs already valid.
- mem_* outputs stay stable from ISSUE until the cycle after mem_done.
- Read, mem_done high in cycle k: rsp_valid high from cycle k+1.
- Write, mem_done high in cycle k: IDLE in cycle k+1. Next pop at end of k+1; next mem_start in k+2.
- Back-to-back overhead per command, excluding subsystem latency: IDLE + ISSUE = 2 cycles; reads add ≥1 RESP cycle.
- rsp_valid never drops without rsp_ready.

## Test plan
- Reset: assert rst 2 cycles mid-stream -> all outputs at reset values, count=0, cmd_ready=1.
- Single write then read: write addr 0x10 data 0xA5, then read 0x10 -> exactly one mem_start per command, in order. Write gives no rsp_valid; read gives rsp_valid with rsp_rdata=0xA5.
- Fill/backpressure (FIFO_DEPTH=4): hold subsystem busy, push 5 reads to addrs 0..4 -> count reaches 4, cmd_ready=0. The 5th is accepted only after a pop. Responses return in address order.
- Response stall: read 0x20 (data 0x3C) with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata=0x3C held. No further mem_start until accepted.
- Simultaneous push/pop at count=2 -> count stays 2; pointer wrap after 8 mixed commands preserves order and data.
- Reset in WAIT, then a late mem_done pulse -> ignored: no rsp_valid, state IDLE, count=0.
